ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 32 bits.
REQ-002 CLK  input  1  sole clock, all state updates on its rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 Ins  input  32  current instruction; Opcode=Ins[31:26], Funct=Ins[5:0], shamt=Ins[10:6].
REQ-005 Rdata1  input  32  rs operand (operand A).
REQ-006 Rdata2  input  32  rt operand (operand B for R-format).
REQ-007 Ed32  input  32  extended immediate (operand B for I-format; zero-extended for ANDI/ORI/XORI by the decode stage).
REQ-008 Result  output  32  ALU result or memory address.
REQ-009 Zero  output  1  high when Result==0.
REQ-010 Busy  output  1  stall request; upstream SHALL hold Ins, Rdata1, Rdata2 and Ed32 constant while Busy=1.

Function
REQ-011 Non-mul/div ops SHALL be combinational with zero latency and Busy=0.
REQ-012 R-format (Opcode 0x00) by Funct: 0x20/0x21 add, 0x22/0x23 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A signed slt, 0x2B unsigned sltu.
REQ-013 R-format shifts: 0x00 sll, 0x02 srl, 0x03 sra by shamt; 0x04 sllv, 0x06 srlv, 0x07 srav by Rdata1[4:0], shifting Rdata2.
REQ-014 I-format: 0x08/0x09 A+Ed32, 0x0A signed slt, 0x0B unsigned slt, 0x0C and, 0x0D or, 0x0E xor, 0x0F Ed32[15:0]<<16, 0x23/0x2B A+Ed32 (address), 0x04/0x05 A-Rdata2 (Zero feeds branch).
REQ-015 All arithmetic SHALL wrap modulo 2^32; overflow raises no trap.
REQ-016 Undecoded opcodes/functs SHALL give Result=0.
REQ-017 HI and LO SHALL be 32-bit registers; MFHI (0x10)/MFLO (0x12) drive Result=HI/LO; MTHI (0x11)/MTLO (0x13) load Rdata1 at the clock edge when Busy=0.
REQ-018 FSM states: IDLE, RUN, DONE.
REQ-019 IDLE, Ins is MULT 0x18/MULTU 0x19/DIV 0x1A/DIVU 0x1B: Busy=1 combinationally, operands latched, step counter=0, next state RUN.
REQ-020 RUN: one shift-add (mul) or restoring-subtract (div) step per cycle, Busy=1; after the 32nd step, HI/LO written and next state DONE.
REQ-021 DONE: Busy=0, held instruction retires without restarting; next state IDLE.
REQ-022 Busy SHALL therefore be high for exactly 33 consecutive cycles per mul/div.
REQ-023 MULT/MULTU: {HI,LO}=64-bit signed/unsigned product.
REQ-024 DIV/DIVU: LO=quotient, HI=remainder; signed quotient truncates toward zero, remainder takes the dividend's sign.
REQ-025 Divide by zero: LO=0xFFFFFFFF, HI=dividend, no exception.
REQ-026 DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
REQ-027 MFHI/MFLO/MTHI/MTLO presented while Busy=1 SHALL be stalled by upstream, never executed mid-operation.

Reset
REQ-028 RST=1 SHALL immediately force state IDLE, counter 0, HI=LO=0 and internal operand/accumulator registers 0.
REQ-029 During reset Busy=0 and Result follows the combinational decode, with MFHI/MFLO returning 0.
REQ-030 Reset asserted during RUN SHALL abandon the operation without updating HI/LO beyond zero.

Configuration
REQ-031 Macro MULDIV_EN defined: HI/LO, FSM and mul/div datapath SHALL be present as specified above.
REQ-032 MULDIV_EN undefined: HI/LO, FSM and mul/div datapath SHALL be absent; Busy SHALL be tied to 0; MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO SHALL give Result=0 with no state change.

Verification
REQ-033 Opcode 0x00 Funct 0x22, Rdata1=5, Rdata2=5 -> Result=0, Zero=1, Busy=0 in the same cycle.
REQ-034 Opcode 0x0F, Ed32=0x00001234 -> Result=0x12340000; Opcode 0x0A, Rdata1=0xFFFFFFFF, Ed32=1 -> Result=1.
REQ-035 MULT with Rdata1=0xFFFFFFFE (-2) and Rdata2=3, held while Busy -> Busy high for 33 cycles; then MFHI=0xFFFFFFFF and MFLO=0xFFFFFFFA.
REQ-036 DIV with Rdata1=0xFFFFFFF9 (-7) and Rdata2=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
REQ-037 Start DIVU 100/7, assert RST at RUN cycle 10 -> Busy drops at once, MFLO=0, and a new DIVU 100/7 gives LO=14, HI=2.
REQ-038 Build without MULDIV_EN, present MULT -> Busy stays 0 and Result=0.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage -- execute stage: combinational ALU plus an optional iterative
// multiply/divide unit with HI/LO registers.
//
// Optional feature macro: MULDIV_EN
//   defined   : HI/LO registers, IDLE/RUN/DONE sequencer and a shared
//               shift-add / restoring-divide datapath (33 Busy cycles per op).
//   undefined : no HI/LO, no sequencer; Busy tied low, mul/div and HI/LO
//               moves decode to Result=0.
//
// Ports:
//   CLK     clock, rising edge
//   RST     asynchronous active-high reset
//   Ins     instruction (opcode [31:26], shamt [10:6], funct [5:0])
//   Rdata1  operand A (rs)
//   Rdata2  operand B for R-format (rt)
//   Ed32    extended immediate, operand B for I-format
//   Result  ALU result / memory address
//   Zero    Result == 0
//   Busy    stall request while a mul/div is in flight
module ex_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Ins,
  input  logic [31:0] Rdata1,
  input  logic [31:0] Rdata2,
  input  logic [31:0] Ed32,
  output logic [31:0] Result,
  output logic        Zero,
  output logic        Busy
);

  localparam logic [5:0] OP_R    = 6'h00, OP_BEQ  = 6'h04, OP_BNE  = 6'h05,
                         OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                         OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D,
                         OP_XORI = 6'h0E, OP_LUI  = 6'h0F, OP_LW   = 6'h23,
                         OP_SW   = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03,
                         F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07,
                         F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12,
                         F_MTLO = 6'h13, F_ADD = 6'h20, F_ADDU = 6'h21,
                         F_SUB = 6'h22, F_SUBU = 6'h23, F_AND = 6'h24,
                         F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27,
                         F_SLT = 6'h2A, F_SLTU = 6'h2B;

  logic [5:0] opcode, funct;
  logic [4:0] shamt;
  assign opcode = Ins[31:26];
  assign funct  = Ins[5:0];
  assign shamt  = Ins[10:6];

`ifdef MULDIV_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] hi, lo;
  logic [31:0] acc_hi, acc_lo, opb;
  logic        op_div, neg_lo, neg_hi;

  logic        md_op, md_signed, a_neg, b_neg;
  logic [31:0] a_abs, b_abs;
  logic [32:0] mul_sum, div_sh;
  logic [33:0] div_diff;
  logic        div_ge;
  logic [31:0] step_hi, step_lo, fin_hi, fin_lo;
  logic [63:0] prod;

  // MULT/MULTU/DIV/DIVU occupy funct 0x18..0x1B: bit1 selects divide,
  // bit0 selects unsigned.
  assign md_op     = (opcode == OP_R) && (funct[5:2] == 4'b0110);
  assign md_signed = ~funct[0];
  assign a_neg     = md_signed & Rdata1[31];
  assign b_neg     = md_signed & Rdata2[31];
  assign a_abs     = a_neg ? -Rdata1 : Rdata1;
  assign b_abs     = b_neg ? -Rdata2 : Rdata2;

  // Both ops work on magnitudes held in {acc_hi, acc_lo}; acc_lo starts as
  // the multiplier / dividend, opb holds the multiplicand / divisor.
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : 33'd0);
  assign div_sh   = {acc_hi, acc_lo[31]};
  // One extra bit so a zero divisor (partial remainder can reach 33 bits)
  // is never mistaken for a borrow.
  assign div_diff = {1'b0, div_sh} - {2'b00, opb};
  assign div_ge   = ~div_diff[33];

  always_comb begin
    if (op_div) begin
      step_hi = div_ge ? div_diff[31:0] : div_sh[31:0];
      step_lo = {acc_lo[30:0], div_ge};
    end else begin
      step_hi = mul_sum[32:1];
      step_lo = {mul_sum[0], acc_lo[31:1]};
    end
  end

  // Sign fix-up applied on the final step only.
  always_comb begin
    prod = {step_hi, step_lo};
    if (op_div) begin
      fin_lo = neg_lo ? -step_lo : step_lo;
      fin_hi = neg_hi ? -step_hi : step_hi;
    end else begin
      if (neg_lo) prod = -prod;
      fin_hi = prod[63:32];
      fin_lo = prod[31:0];
    end
  end

  // State register and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      acc_hi <= 32'd0;
      acc_lo <= 32'd0;
      opb    <= 32'd0;
      op_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (md_op) begin
            acc_hi <= 32'd0;
            acc_lo <= a_abs;
            opb    <= b_abs;
            cnt    <= 5'd0;
            op_div <= funct[1];
            // Divide by zero keeps the all-ones quotient un-negated.
            neg_lo <= (a_neg ^ b_neg) & ~(funct[1] & (Rdata2 == 32'd0));
            neg_hi <= a_neg;
          end else if (opcode == OP_R && funct == F_MTHI) begin
            hi <= Rdata1;
          end else if (opcode == OP_R && funct == F_MTLO) begin
            lo <= Rdata1;
          end
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            hi <= fin_hi;
            lo <= fin_lo;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (md_op) state_nxt = RUN;
      RUN:     if (cnt == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: Busy covers the launch cycle plus the 32 RUN steps.
  always_comb begin
    Busy = 1'b0;
    if (!RST) begin
      case (state)
        IDLE:    Busy = md_op;
        RUN:     Busy = 1'b1;
        default: Busy = 1'b0;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{Ins[25:11]};
`else
  assign Busy = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{CLK, RST, Ins[25:11]};
`endif

  // Combinational ALU / address / HI-LO read mux.
  always_comb begin
    Result = 32'd0;
    case (opcode)
      OP_R: begin
        case (funct)
          F_ADD, F_ADDU: Result = Rdata1 + Rdata2;
          F_SUB, F_SUBU: Result = Rdata1 - Rdata2;
          F_AND:  Result = Rdata1 & Rdata2;
          F_OR:   Result = Rdata1 | Rdata2;
          F_XOR:  Result = Rdata1 ^ Rdata2;
          F_NOR:  Result = ~(Rdata1 | Rdata2);
          F_SLT:  Result = {31'd0, $signed(Rdata1) < $signed(Rdata2)};
          F_SLTU: Result = {31'd0, Rdata1 < Rdata2};
          F_SLL:  Result = Rdata2 << shamt;
          F_SRL:  Result = Rdata2 >> shamt;
          F_SRA:  Result = $unsigned($signed(Rdata2) >>> shamt);
          F_SLLV: Result = Rdata2 << Rdata1[4:0];
          F_SRLV: Result = Rdata2 >> Rdata1[4:0];
          F_SRAV: Result = $unsigned($signed(Rdata2) >>> Rdata1[4:0]);
`ifdef MULDIV_EN
          F_MFHI: Result = hi;
          F_MFLO: Result = lo;
`endif
          default: Result = 32'd0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: Result = Rdata1 + Ed32;
      OP_SLTI:  Result = {31'd0, $signed(Rdata1) < $signed(Ed32)};
      OP_SLTIU: Result = {31'd0, Rdata1 < Ed32};
      OP_ANDI:  Result = Rdata1 & Ed32;
      OP_ORI:   Result = Rdata1 | Ed32;
      OP_XORI:  Result = Rdata1 ^ Ed32;
      OP_LUI:   Result = {Ed32[15:0], 16'd0};
      OP_BEQ, OP_BNE: Result = Rdata1 - Rdata2;
      default:  Result = 32'd0;
    endcase
  end

  assign Zero = (Result == 32'd0);

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage. Mul/div scenarios are compiled in when
// MULDIV_EN is defined; otherwise the disabled-feature behaviour is checked.
module tb_ex_stage;
  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Ins, Rdata1, Rdata2, Ed32;
  logic [31:0] Result;
  logic        Zero, Busy;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  ex_stage dut (
    .CLK(CLK), .RST(RST), .Ins(Ins), .Rdata1(Rdata1), .Rdata2(Rdata2),
    .Ed32(Ed32), .Result(Result), .Zero(Zero), .Busy(Busy)
  );

  function automatic logic [31:0] rins(input logic [5:0] f, input logic [4:0] sh);
    return {6'h00, 15'd0, sh, f};
  endfunction

  function automatic logic [31:0] iins(input logic [5:0] op);
    return {op, 26'd0};
  endfunction

  // Apply inputs away from the rising edge and let the comb logic settle.
  task automatic drive(input logic [31:0] i, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] e);
    @(negedge CLK);
    Ins = i; Rdata1 = a; Rdata2 = b; Ed32 = e;
    #1;
  endtask

  // Launch a mul/div and hold it until Busy drops; cyc = Busy cycles seen.
  task automatic run_md(input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, output int cyc);
    drive(rins(f, 5'd0), a, b, 32'd0);
    cyc = 0;
    while (Busy === 1'b1 && cyc < 100) begin
      @(posedge CLK); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    drive(rins(6'h18, 5'd0), 32'd3, 32'd4, 32'd0);
    tests++;
    if (Busy !== 1'b0) begin
      fails++; $display("FAIL reset_busy: Busy=%b expected 0", Busy);
    end
    drive(rins(6'h10, 5'd0), 32'd0, 32'd0, 32'd0);
    tests++;
    if (Result !== 32'd0) begin
      fails++; $display("FAIL reset_mfhi: Result=%h expected 00000000", Result);
    end
    drive(rins(6'h12, 5'd0), 32'd0, 32'd0, 32'd0);
    tests++;
    if (Result !== 32'd0) begin
      fails++; $display("FAIL reset_mflo: Result=%h expected 00000000", Result);
    end
    drive(rins(6'h20, 5'd0), 32'd2, 32'd3, 32'd0);
    tests++;
    if (Result !== 32'd5) begin
      fails++; $display("FAIL reset_alu: Result=%h expected 00000005", Result);
    end
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_alu;
    // {Ins, Rdata1, Rdata2, Ed32, expected Result}
    logic [159:0] v [26];
    v[0]  = {rins(6'h22, 5'd0),  32'd5,        32'd5,        32'd0,        32'd0};
    v[1]  = {rins(6'h21, 5'd0),  32'hFFFFFFFF, 32'd1,        32'd0,        32'd0};
    v[2]  = {rins(6'h24, 5'd0),  32'hF0F000FF, 32'h0FF00F0F, 32'd0,        32'h00F0000F};
    v[3]  = {rins(6'h27, 5'd0),  32'd0,        32'd0,        32'd0,        32'hFFFFFFFF};
    v[4]  = {rins(6'h26, 5'd0),  32'hAAAA5555, 32'hFFFF0000, 32'd0,        32'h55555555};
    v[5]  = {rins(6'h2A, 5'd0),  32'hFFFFFFFF, 32'd1,        32'd0,        32'd1};
    v[6]  = {rins(6'h2B, 5'd0),  32'hFFFFFFFF, 32'd1,        32'd0,        32'd0};
    v[7]  = {rins(6'h00, 5'd8),  32'd0,        32'h12,       32'd0,        32'h1200};
    v[8]  = {rins(6'h03, 5'd4),  32'd0,        32'h80000000, 32'd0,        32'hF8000000};
    v[9]  = {rins(6'h06, 5'd0),  32'h24,       32'h80000000, 32'd0,        32'h08000000};
    v[10] = {rins(6'h02, 5'd31), 32'd0,        32'h80000000, 32'd0,        32'd1};
    v[11] = {rins(6'h3F, 5'd0),  32'd1,        32'd2,        32'd0,        32'd0};
    v[12] = {rins(6'h25, 5'd0),  32'h0F00,     32'h00F0,     32'd0,        32'h0FF0};
    v[13] = {iins(6'h0F),        32'hFFFF,     32'd0,        32'h1234,     32'h12340000};
    v[14] = {iins(6'h0A),        32'hFFFFFFFF, 32'd0,        32'd1,        32'd1};
    v[15] = {iins(6'h0B),        32'hFFFFFFFF, 32'd0,        32'd1,        32'd0};
    v[16] = {iins(6'h0D),        32'h0F00,     32'd0,        32'h00FF,     32'h0FFF};
    v[17] = {iins(6'h23),        32'h1000,     32'd0,        32'hFFFFFFFC, 32'h0FFC};
    v[18] = {iins(6'h04),        32'd7,        32'd7,        32'd99,       32'd0};
    v[19] = {iins(6'h05),        32'd3,        32'd7,        32'd0,        32'hFFFFFFFC};
    v[20] = {iins(6'h08),        32'h7FFFFFFF, 32'd0,        32'd1,        32'h80000000};
    v[21] = {iins(6'h0C),        32'h1234,     32'd0,        32'h00FF,     32'h34};
    v[22] = {iins(6'h0E),        32'hFF,       32'd0,        32'h0F,       32'hF0};
    v[23] = {iins(6'h3F),        32'd5,        32'd6,        32'd7,        32'd0};
    v[24] = {iins(6'h2B),        32'h10,       32'd0,        32'h8,        32'h18};
    v[25] = {rins(6'h23, 5'd0),  32'd0,        32'd1,        32'd0,        32'hFFFFFFFF};
    for (int i = 0; i < 26; i++) begin
      logic [31:0] exp;
      exp = v[i][31:0];
      drive(v[i][159:128], v[i][127:96], v[i][95:64], v[i][63:32]);
      tests++;
      if ({Result, Zero, Busy} !== {exp, exp == 32'd0, 1'b0}) begin
        fails++;
        $display("FAIL alu[%0d]: Result=%h Zero=%b Busy=%b expected %h/%b/0",
                 i, Result, Zero, Busy, exp, exp == 32'd0);
      end
    end
  endtask

`ifdef MULDIV_EN
  task automatic test_mult;
    logic [5:0]  f   [3] = '{6'h18, 6'h19, 6'h18};
    logic [31:0] a   [3] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] b   [3] = '{32'd3,        32'hFFFFFFFF, 32'h80000000};
    logic [31:0] ehi [3] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h40000000};
    logic [31:0] elo [3] = '{32'hFFFFFFFA, 32'h00000001, 32'h00000000};
    int cyc;
    for (int i = 0; i < 3; i++) begin
      run_md(f[i], a[i], b[i], cyc);
      tests++;
      if (cyc != 33) begin
        fails++; $display("FAIL mult[%0d]_busy: cycles=%0d expected 33", i, cyc);
      end
      drive(rins(6'h10, 5'd0), 32'd0, 32'd0, 32'd0);
      tests++;
      if (Result !== ehi[i]) begin
        fails++; $display("FAIL mult[%0d]_hi: Result=%h expected %h", i, Result, ehi[i]);
      end
      drive(rins(6'h12, 5'd0), 32'd0, 32'd0, 32'd0);
      tests++;
      if (Result !== elo[i]) begin
        fails++; $display("FAIL mult[%0d]_lo: Result=%h expected %h", i, Result, elo[i]);
      end
    end
  endtask

  task automatic test_div;
    logic [5:0]  f   [6] = '{6'h1A, 6'h1B, 6'h1A, 6'h1A, 6'h1B, 6'h1A};
    logic [31:0] a   [6] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFF9,
                             32'hFFFFFFFF, 32'd7};
    logic [31:0] b   [6] = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'd0, 32'h10, 32'hFFFFFFFE};
    logic [31:0] ehi [6] = '{32'hFFFFFFFF, 32'd7, 32'd0, 32'hFFFFFFF9, 32'hF, 32'd1};
    logic [31:0] elo [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF,
                             32'h0FFFFFFF, 32'hFFFFFFFD};
    int cyc;
    for (int i = 0; i < 6; i++) begin
      run_md(f[i], a[i], b[i], cyc);
      tests++;
      if (cyc != 33) begin
        fails++; $display("FAIL div[%0d]_busy: cycles=%0d expected 33", i, cyc);
      end
      drive(rins(6'h10, 5'd0), 32'd0, 32'd0, 32'd0);
      tests++;
      if (Result !== ehi[i]) begin
        fails++; $display("FAIL div[%0d]_hi: Result=%h expected %h", i, Result, ehi[i]);
      end
      drive(rins(6'h12, 5'd0), 32'd0, 32'd0, 32'd0);
      tests++;
      if (Result !== elo[i]) begin
        fails++; $display("FAIL div[%0d]_lo: Result=%h expected %h", i, Result, elo[i]);
      end
    end
  endtask

  task automatic test_mthilo;
    drive(rins(6'h11, 5'd0), 32'hDEADBEEF, 32'd0, 32'd0);
    tests++;
    if (Busy !== 1'b0) begin
      fails++; $display("FAIL mthi_busy: Busy=%b expected 0", Busy);
    end
    drive(rins(6'h13, 5'd0), 32'h12345678, 32'd0, 32'd0);
    drive(rins(6'h10, 5'd0), 32'd0, 32'd0, 32'd0);
    tests++;
    if (Result !== 32'hDEADBEEF) begin
      fails++; $display("FAIL mthi: Result=%h expected deadbeef", Result);
    end
    drive(rins(6'h12, 5'd0), 32'd0, 32'd0, 32'd0);
    tests++;
    if (Result !== 32'h12345678) begin
      fails++; $display("FAIL mtlo: Result=%h expected 12345678", Result);
    end
  endtask

  task automatic test_reset_midrun;
    int cyc;
    drive(rins(6'h1B, 5'd0), 32'd100, 32'd7, 32'd0);
    repeat (11) begin @(posedge CLK); #1; end
    tests++;
    if (Busy !== 1'b1) begin
      fails++; $display("FAIL midrun_busy: Busy=%b expected 1", Busy);
    end
    RST = 1'b1;
    #1;
    tests++;
    if (Busy !== 1'b0) begin
      fails++; $display("FAIL midrun_reset_busy: Busy=%b expected 0", Busy);
    end
    drive(rins(6'h12, 5'd0), 32'd0, 32'd0, 32'd0);
    tests++;
    if (Result !== 32'd0) begin
      fails++; $display("FAIL midrun_reset_lo: Result=%h expected 00000000", Result);
    end
    drive(rins(6'h10, 5'd0), 32'd0, 32'd0, 32'd0);
    tests++;
    if (Result !== 32'd0) begin
      fails++; $display("FAIL midrun_reset_hi: Result=%h expected 00000000", Result);
    end
    @(negedge CLK);
    RST = 1'b0;
    run_md(6'h1B, 32'd100, 32'd7, cyc);
    tests++;
    if (cyc != 33) begin
      fails++; $display("FAIL rerun_busy: cycles=%0d expected 33", cyc);
    end
    drive(rins(6'h12, 5'd0), 32'd0, 32'd0, 32'd0);
    tests++;
    if (Result !== 32'd14) begin
      fails++; $display("FAIL rerun_lo: Result=%h expected 0000000e", Result);
    end
    drive(rins(6'h10, 5'd0), 32'd0, 32'd0, 32'd0);
    tests++;
    if (Result !== 32'd2) begin
      fails++; $display("FAIL rerun_hi: Result=%h expected 00000002", Result);
    end
  endtask
`else
  task automatic test_no_muldiv;
    drive(rins(6'h18, 5'd0), 32'hFFFFFFFE, 32'd3, 32'd0);
    tests++;
    if ({Result, Busy} !== {32'd0, 1'b0}) begin
      fails++; $display("FAIL nomd_mult: Result=%h Busy=%b expected 00000000/0", Result, Busy);
    end
    repeat (3) begin @(posedge CLK); #1; end
    tests++;
    if (Busy !== 1'b0) begin
      fails++; $display("FAIL nomd_busy_hold: Busy=%b expected 0", Busy);
    end
    drive(rins(6'h1A, 5'd0), 32'd100, 32'd7, 32'd0);
    tests++;
    if ({Result, Busy} !== {32'd0, 1'b0}) begin
      fails++; $display("FAIL nomd_div: Result=%h Busy=%b expected 00000000/0", Result, Busy);
    end
    drive(rins(6'h11, 5'd0), 32'hDEADBEEF, 32'd0, 32'd0);
    tests++;
    if (Result !== 32'd0) begin
      fails++; $display("FAIL nomd_mthi: Result=%h expected 00000000", Result);
    end
    drive(rins(6'h10, 5'd0), 32'hDEADBEEF, 32'd0, 32'd0);
    tests++;
    if (Result !== 32'd0) begin
      fails++; $display("FAIL nomd_mfhi: Result=%h expected 00000000", Result);
    end
    drive(rins(6'h12, 5'd0), 32'hDEADBEEF, 32'd0, 32'd0);
    tests++;
    if (Result !== 32'd0) begin
      fails++; $display("FAIL nomd_mflo: Result=%h expected 00000000", Result);
    end
  endtask
`endif

  initial begin
    RST = 1'b1; Ins = 32'd0; Rdata1 = 32'd0; Rdata2 = 32'd0; Ed32 = 32'd0;
    test_reset;
    test_alu;
`ifdef MULDIV_EN
    test_mult;
    test_div;
    test_mthilo;
    test_reset_midrun;
`else
    test_no_muldiv;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
